// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM stage: data-memory load/store over req/ack with MEM/WB register
//
// Ports:
//   clk, rst (sync, active-low)
//   *M inputs      : control, destination, link value, store data and address from EX
//   dmem_* outputs : doubleword-aligned bus request with byte-lane strobes and data
//   dmem_ack/rdata : bus completion and read data
//   StallM         : holds upstream stages while an access is outstanding
//   *W outputs     : MEM/WB register, plus one-cycle MisalignW / BusErrW flags

module memory_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteEnM,
    input  logic        MemtoRegM,
    input  logic        JALM,
    input  logic        MemReadEnM,
    input  logic        MemWriteEnM,
    input  logic [1:0]  MemSizeM,
    input  logic [1:0]  LoadSizeM,
    input  logic [4:0]  RdM,
    input  logic [63:0] PcPlus4M,
    input  logic [63:0] ReadData2M,
    input  logic [63:0] ALUResultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteEnW,
    output logic        MemtoRegW,
    output logic        JALW,
    output logic [4:0]  RdW,
    output logic [63:0] PcPlus4W,
    output logic [63:0] ALUResultW,
    output logic [63:0] ReadDataW,
    output logic        MisalignW,
    output logic        BusErrW
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]      state;
    logic [TO_W-1:0] waitCnt;

    logic        isAccess;
    logic        isStore;
    logic [1:0]  accSize;
    logic [2:0]  offset;
    logic        misaligned;
    logic        alignedAccess;
    logic        timedOut;
    logic        reqActive;
    logic        complete;
    logic        captureM;
    logic [7:0]  laneStrb;
    logic [63:0] laneWdata;
    logic [63:0] laneData;
    logic [63:0] loadData;

    always_comb begin
        isAccess = MemReadEnM | MemWriteEnM;
        // A store wins when both enables are set.
        isStore  = MemWriteEnM;
        accSize  = isStore ? MemSizeM : LoadSizeM;
        offset   = ALUResultM[2:0];
        case (accSize)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset[1:0];
            default: misaligned = |offset;
        endcase
        alignedAccess = isAccess & ~misaligned;
    end

    // waitCnt holds (cycles already stalled - 1) while in WAIT, so the IDLE
    // request cycle counts toward the budget and StallM is high for exactly
    // TIMEOUT_CYCLES cycles before the abort cycle.
    assign timedOut = (state == WAIT) && (waitCnt == TO_W'(TIMEOUT_CYCLES - 1));

    // In WAIT the *M inputs are frozen, so the request keeps its original
    // address/data without needing a local copy.
    assign reqActive = rst && ((state == IDLE) ? alignedAccess : ~timedOut);
    assign complete  = rst && dmem_ack && (((state == IDLE) && alignedAccess) || (state == WAIT));
    assign captureM  = ((state == IDLE) && !isAccess) || complete;

    always_comb begin
        case (accSize)
            2'b00: begin
                laneStrb  = 8'b0000_0001 << offset;
                laneWdata = {8{ReadData2M[7:0]}};
            end
            2'b01: begin
                laneStrb  = 8'b0000_0011 << offset;
                laneWdata = {4{ReadData2M[15:0]}};
            end
            2'b10: begin
                laneStrb  = 8'h0F << offset;
                laneWdata = {2{ReadData2M[31:0]}};
            end
            default: begin
                laneStrb  = 8'hFF;
                laneWdata = ReadData2M;
            end
        endcase
    end

    assign dmem_req   = reqActive;
    assign dmem_we    = reqActive & isStore;
    assign dmem_wstrb = (reqActive & isStore) ? laneStrb : 8'h00;
    assign dmem_wdata = laneWdata;
    assign dmem_addr  = {ALUResultM[63:3], 3'b000};
    assign StallM     = reqActive & ~dmem_ack;

    // Move the addressed lane down to bit 0, then sign-extend by load size.
    always_comb begin
        laneData = dmem_rdata >> {offset, 3'b000};
        case (LoadSizeM)
            2'b00:   loadData = {{56{laneData[7]}},  laneData[7:0]};
            2'b01:   loadData = {{48{laneData[15]}}, laneData[15:0]};
            2'b10:   loadData = {{32{laneData[31]}}, laneData[31:0]};
            default: loadData = laneData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            waitCnt     <= '0;
            RegWriteEnW <= 1'b0;
            MemtoRegW   <= 1'b0;
            JALW        <= 1'b0;
            RdW         <= 5'd0;
            PcPlus4W    <= 64'd0;
            ALUResultW  <= 64'd0;
            ReadDataW   <= 64'd0;
            MisalignW   <= 1'b0;
            BusErrW     <= 1'b0;
        end else begin
            if (captureM) begin
                RegWriteEnW <= RegWriteEnM;
                MemtoRegW   <= MemtoRegM;
                JALW        <= JALM;
                RdW         <= RdM;
                PcPlus4W    <= PcPlus4M;
                ALUResultW  <= ALUResultM;
                ReadDataW   <= (complete && !isStore) ? loadData : 64'd0;
            end else begin
                // Bubble: stalled, squashed or aborted access.
                RegWriteEnW <= 1'b0;
                MemtoRegW   <= 1'b0;
                JALW        <= 1'b0;
                RdW         <= 5'd0;
                PcPlus4W    <= 64'd0;
                ALUResultW  <= 64'd0;
                ReadDataW   <= 64'd0;
            end

            MisalignW <= (state == IDLE) && isAccess && misaligned;
            BusErrW   <= timedOut && !dmem_ack;

            case (state)
                IDLE: begin
                    if (alignedAccess && !dmem_ack) begin
                        state   <= WAIT;
                        waitCnt <= '0;
                    end
                end
                default: begin
                    if (dmem_ack || timedOut) begin
                        state <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + TO_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage

module tb_memory_stage;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM;
    logic [1:0]  MemSizeM, LoadSizeM;
    logic [4:0]  RdM;
    logic [63:0] PcPlus4M, ReadData2M, ALUResultM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wstrb;
    logic        StallM;
    logic        RegWriteEnW, MemtoRegW, JALW, MisalignW, BusErrW;
    logic [4:0]  RdW;
    logic [63:0] PcPlus4W, ALUResultW, ReadDataW;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT_CYCLES(TMO), .TO_W(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteEnM(RegWriteEnM), .MemtoRegM(MemtoRegM), .JALM(JALM),
        .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM),
        .MemSizeM(MemSizeM), .LoadSizeM(LoadSizeM), .RdM(RdM),
        .PcPlus4M(PcPlus4M), .ReadData2M(ReadData2M), .ALUResultM(ALUResultM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .StallM(StallM),
        .RegWriteEnW(RegWriteEnW), .MemtoRegW(MemtoRegW), .JALW(JALW),
        .RdW(RdW), .PcPlus4W(PcPlus4W), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] loadVal(input logic [63:0] rd, input int off, input logic [1:0] sz);
        int n;
        logic [63:0] v;
        n = 1 << sz;
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*((off + i) % 8) +: 8];
        if (n < 8 && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] strbOf(input int off, input logic [1:0] sz);
        int n;
        logic [7:0] s;
        n = 1 << sz;
        for (int i = 0; i < 8; i++) s[i] = (i >= off) && (i < off + n);
        return s;
    endfunction

    function automatic logic [63:0] wdataOf(input logic [63:0] wd, input logic [1:0] sz);
        int n;
        logic [63:0] d;
        n = 1 << sz;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = wd[8*(i % n) +: 8];
        return d;
    endfunction

    int          waited = 0;   // cycles the current access has been stalled
    logic        eRwe, eM2r, eJal, eMis, eBerr, eFull;
    logic [4:0]  eRd;
    logic [63:0] ePc, eAlu, eRdata;

    always @(posedge clk) begin : model
        logic acc, st, mis;
        logic [1:0] sz;
        int off;
        acc = MemReadEnM | MemWriteEnM;
        st  = MemWriteEnM;
        sz  = st ? MemSizeM : LoadSizeM;
        off = int'(ALUResultM[2:0]);
        mis = acc && ((off % (1 << sz)) != 0);
        eRwe = 0; eM2r = 0; eJal = 0; eMis = 0; eBerr = 0; eFull = 0;
        eRd = 0; ePc = 0; eAlu = 0; eRdata = 0;
        if (!rst) begin
            eFull = 1; waited = 0;
        end else if (!acc || mis || dmem_ack) begin
            if (mis) eMis = 1;
            else begin
                eRwe = RegWriteEnM; eM2r = MemtoRegM; eJal = JALM; eRd = RdM;
                ePc = PcPlus4M; eAlu = ALUResultM; eFull = 1;
                eRdata = (acc && !st) ? loadVal(dmem_rdata, off, LoadSizeM) : 64'd0;
            end
            waited = 0;
        end else if (waited == TMO) begin
            eBerr = 1; waited = 0;
        end else begin
            waited++;
        end
    end

    always @(negedge clk) begin : cmp
        logic acc, st, mis, xReq, xStall;
        logic [1:0] sz;
        int off;
        acc = MemReadEnM | MemWriteEnM;
        st  = MemWriteEnM;
        sz  = st ? MemSizeM : LoadSizeM;
        off = int'(ALUResultM[2:0]);
        mis = acc && ((off % (1 << sz)) != 0);
        if (!rst || !acc || mis || waited == TMO) begin
            xReq = 0; xStall = 0;
        end else begin
            xReq = 1; xStall = !dmem_ack;
        end
        chk("dmem_req", 64'(dmem_req), 64'(xReq));
        chk("StallM", 64'(StallM), 64'(xStall));
        chk("dmem_we", 64'(dmem_we), 64'(xReq && st));
        chk("dmem_wstrb", 64'(dmem_wstrb), 64'((xReq && st) ? strbOf(off, sz) : 8'h00));
        if (xReq) chk("dmem_addr", dmem_addr, {ALUResultM[63:3], 3'b000});
        if (xReq && st) chk("dmem_wdata", dmem_wdata, wdataOf(ReadData2M, sz));
        chk("RegWriteEnW", 64'(RegWriteEnW), 64'(eRwe));
        chk("MemtoRegW", 64'(MemtoRegW), 64'(eM2r));
        chk("JALW", 64'(JALW), 64'(eJal));
        chk("MisalignW", 64'(MisalignW), 64'(eMis));
        chk("BusErrW", 64'(BusErrW), 64'(eBerr));
        if (eFull) begin
            chk("RdW", 64'(RdW), 64'(eRd));
            chk("PcPlus4W", PcPlus4W, ePc);
            chk("ALUResultW", ALUResultW, eAlu);
            chk("ReadDataW", ReadDataW, eRdata);
        end
    end

    // ---------------- stimulus ----------------
    int          oStall, oReq, oRwePulses;
    logic [7:0]  oStrb;
    logic [63:0] oWdata, oAddr, oRdata, oAlu, oPc;
    logic        oWe, oRwe, oJal, oMis, oBerr;
    logic [4:0]  oRd;

    task automatic setNop();
        RegWriteEnM = 0; MemtoRegM = 0; JALM = 0; MemReadEnM = 0; MemWriteEnM = 0;
        MemSizeM = 0; LoadSizeM = 0; RdM = 0; PcPlus4M = 0; ReadData2M = 0;
        ALUResultM = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // ackAfter: stall cycles before ack (0 = zero-wait, -1 = never)
    task automatic issue(input logic re, input logic we, input logic [1:0] sz,
                         input logic rwe, input logic m2r, input logic jal,
                         input logic [4:0] rd, input logic [63:0] alu,
                         input logic [63:0] wd, input logic [63:0] rdata, input int ackAfter);
        logic mis;
        RegWriteEnM = rwe; MemtoRegM = m2r; JALM = jal; MemReadEnM = re; MemWriteEnM = we;
        MemSizeM  = we ? sz : ~sz;
        LoadSizeM = we ? ~sz : sz;
        RdM = rd; PcPlus4M = 64'hC000_0000 | alu; ReadData2M = wd; ALUResultM = alu;
        dmem_rdata = rdata;
        mis = (int'(alu[2:0]) % (1 << sz)) != 0;
        oStall = 0; oReq = 0; oRwePulses = 0;
        for (int cyc = 0; cyc <= TMO + 1; cyc++) begin
            dmem_ack = (cyc == ackAfter);
            @(negedge clk);
            oStall += int'(StallM);
            oReq += int'(dmem_req);
            oRwePulses += int'(RegWriteEnW);
            if (cyc == 0) begin
                oStrb = dmem_wstrb; oWdata = dmem_wdata; oAddr = dmem_addr; oWe = dmem_we;
            end
            @(posedge clk); #1;
            if (!(re || we) || mis || cyc == ackAfter || cyc == TMO) break;
        end
        setNop();
        @(negedge clk);
        oRwe = RegWriteEnW; oJal = JALW; oMis = MisalignW; oBerr = BusErrW;
        oRd = RdW; oRdata = ReadDataW; oAlu = ALUResultW; oPc = PcPlus4W;
        oRwePulses += int'(RegWriteEnW);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 0;
        setNop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset RegWriteEnW", 64'(RegWriteEnW), 64'd0);
        chk("reset dmem_req", 64'(dmem_req), 64'd0);
        @(posedge clk); #1;
        rst = 1;

        // ALU op
        issue(0, 0, 2'b00, 1, 0, 0, 5'd1, 64'd25, 64'd0, 64'd0, -1);
        chk("alu ALUResultW", oAlu, 64'd25);
        chk("alu RdW", 64'(oRd), 64'd1);
        chk("alu RegWriteEnW", 64'(oRwe), 64'd1);
        chk("alu req count", 64'(oReq), 64'd0);
        chk("alu stall count", 64'(oStall), 64'd0);

        // lw 0x208, ack after 2 stall cycles
        issue(1, 0, 2'b10, 1, 1, 0, 5'd5, 64'h208, 64'd0, 64'h0000_0000_8000_1234, 2);
        chk("lw stall count", 64'(oStall), 64'd2);
        chk("lw addr", oAddr, 64'h208);
        chk("lw ReadDataW", oRdata, 64'hFFFF_FFFF_8000_1234);
        chk("lw RegWriteEnW pulses", 64'(oRwePulses), 64'd1);

        // sb 0x303, zero-wait
        issue(0, 1, 2'b00, 0, 0, 0, 5'd0, 64'h303, 64'hAB, 64'd0, 0);
        chk("sb wstrb", 64'(oStrb), 64'h08);
        chk("sb wdata", oWdata, 64'hABAB_ABAB_ABAB_ABAB);
        chk("sb we", 64'(oWe), 64'd1);
        chk("sb stall count", 64'(oStall), 64'd0);
        chk("sb RegWriteEnW", 64'(oRwe), 64'd0);

        // lh 0x101 misaligned
        issue(1, 0, 2'b01, 1, 1, 0, 5'd7, 64'h101, 64'd0, 64'd0, 0);
        chk("lh-mis req count", 64'(oReq), 64'd0);
        chk("lh-mis MisalignW", 64'(oMis), 64'd1);
        chk("lh-mis RegWriteEnW", 64'(oRwe), 64'd0);

        // sw 0x400, never acked
        issue(0, 1, 2'b10, 0, 0, 0, 5'd0, 64'h400, 64'h1122_3344, 64'd0, -1);
        chk("sw-to stall count", 64'(oStall), 64'd16);
        chk("sw-to req count", 64'(oReq), 64'd16);
        chk("sw-to BusErrW", 64'(oBerr), 64'd1);

        // ld acked exactly on the timeout cycle: ack wins
        issue(1, 0, 2'b11, 1, 1, 0, 5'd9, 64'h210, 64'd0, 64'h8877_6655_4433_2211, TMO);
        chk("ld-late stall count", 64'(oStall), 64'd16);
        chk("ld-late ReadDataW", oRdata, 64'h8877_6655_4433_2211);
        chk("ld-late BusErrW", 64'(oBerr), 64'd0);

        // lb positive, lh negative at upper lanes
        issue(1, 0, 2'b00, 1, 1, 0, 5'd10, 64'h105, 64'd0, 64'h0000_7F00_0000_0000, 1);
        chk("lb ReadDataW", oRdata, 64'h7F);
        issue(1, 0, 2'b01, 1, 1, 0, 5'd11, 64'h106, 64'd0, 64'h8001_0000_0000_0000, 0);
        chk("lh ReadDataW", oRdata, 64'hFFFF_FFFF_FFFF_8001);

        // sh 0x306, sd with both enables set, misaligned sd
        issue(0, 1, 2'b01, 0, 0, 0, 5'd0, 64'h306, 64'h1234, 64'd0, 1);
        chk("sh wstrb", 64'(oStrb), 64'hC0);
        chk("sh wdata", oWdata, 64'h1234_1234_1234_1234);
        issue(1, 1, 2'b11, 0, 0, 0, 5'd3, 64'h218, 64'hDEAD_BEEF_0BAD_F00D, 64'hFFFF, 0);
        chk("sd wstrb", 64'(oStrb), 64'hFF);
        chk("sd we", 64'(oWe), 64'd1);
        chk("sd ReadDataW", oRdata, 64'd0);
        issue(0, 1, 2'b11, 0, 0, 0, 5'd0, 64'h404, 64'd5, 64'd0, 0);
        chk("sd-mis MisalignW", 64'(oMis), 64'd1);

        // JAL
        issue(0, 0, 2'b00, 1, 0, 1, 5'd31, 64'h880, 64'd0, 64'd0, -1);
        chk("jal JALW", 64'(oJal), 64'd1);
        chk("jal PcPlus4W", oPc, 64'hC000_0880);

        // reset while an ld is waiting
        RegWriteEnM = 1; MemtoRegM = 1; MemReadEnM = 1; LoadSizeM = 2'b11; MemSizeM = 2'b00;
        RdM = 5'd12; ALUResultM = 64'h220; PcPlus4M = 64'h224; dmem_ack = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst-mid dmem_req", 64'(dmem_req), 64'd0);
        chk("rst-mid StallM", 64'(StallM), 64'd0);
        @(posedge clk); #1;
        rst = 1;
        setNop();
        @(negedge clk);
        chk("rst-mid RdW", 64'(RdW), 64'd0);
        chk("rst-mid ReadDataW", ReadDataW, 64'd0);
        @(posedge clk); #1;
        issue(1, 0, 2'b10, 1, 1, 0, 5'd13, 64'h228, 64'd0, 64'h0000_0000_7654_3210, 1);
        chk("post-rst stall count", 64'(oStall), 64'd1);
        chk("post-rst ReadDataW", oRdata, 64'h7654_3210);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
